// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences IF/ID/EX/MEM/WB, decodes op/func into datapath and ALU controls.
// Build option MC_CTRL_HAMMING_EN adds the R-type ham instruction (func 111000).
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_rdy,
  output logic             pc_we,
  output logic             ir_we,
  output logic             iord,
  output logic             mem_re,
  output logic             mem_we,
  output logic             reg_we,
  output logic             regdst,
  output logic             m2reg,
  output logic             jal,
  output logic             sext,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsrc,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0100, ALU_AND = 4'b0001,
                         ALU_OR  = 4'b0101, ALU_XOR = 4'b0010, ALU_LUI = 4'b0110,
                         ALU_SLL = 4'b0011, ALU_SRL = 4'b0111, ALU_SRA = 4'b1111,
                         ALU_HAM = 4'b1011;

  localparam logic [5:0] OP_R    = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                         OP_ORI  = 6'b001101, OP_XORI = 6'b001110, OP_LUI  = 6'b001111,
                         OP_LW   = 6'b100011, OP_SW   = 6'b101011, OP_BEQ  = 6'b000100,
                         OP_BNE  = 6'b000101, OP_J    = 6'b000010, OP_JAL  = 6'b000011;

`ifdef MC_CTRL_HAMMING_EN
  localparam bit HAM_EN = 1'b1;
`else
  localparam bit HAM_EN = 1'b0;
`endif

  state_t     state_q;
  logic       r_ok, is_r, is_shift, is_ialu, is_lw, is_sw, is_br, is_j, is_jal, legal;
  logic [3:0] r_aluc, i_aluc;

  // R-type func decode; r_ok qualifies which funcs are legal in this build.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r_ok   = 1'b1;
    r_aluc = ALU_ADD;
    case (func)
      6'b100000: r_aluc = ALU_ADD;
      6'b100010: r_aluc = ALU_SUB;
      6'b100100: r_aluc = ALU_AND;
      6'b100101: r_aluc = ALU_OR;
      6'b100110: r_aluc = ALU_XOR;
      6'b000000: r_aluc = ALU_SLL;
      6'b000010: r_aluc = ALU_SRL;
      6'b000011: r_aluc = ALU_SRA;
      6'b111000: begin r_aluc = ALU_HAM; r_ok = HAM_EN; end
      default:   r_ok   = 1'b0;
    endcase
  end

  always_comb begin
    i_aluc = ALU_ADD;
    case (op)
      OP_ANDI: i_aluc = ALU_AND;
      OP_ORI:  i_aluc = ALU_OR;
      OP_XORI: i_aluc = ALU_XOR;
      OP_LUI:  i_aluc = ALU_LUI;
      default: i_aluc = ALU_ADD;
    endcase
  end

  assign is_r     = (op == OP_R) && r_ok;
  assign is_shift = (func == 6'b000000) || (func == 6'b000010) || (func == 6'b000011);
  assign is_ialu  = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
                    (op == OP_XORI) || (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_br    = (op == OP_BEQ) || (op == OP_BNE);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign legal    = is_r || is_ialu || is_lw || is_sw || is_br || is_j || is_jal;

  // Sequencing; retire_cnt steps only on transitions that finish an instruction.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q    <= S_IF;
      retire_cnt <= '0;
    end else begin
      case (state_q)
        S_IF: if (mem_rdy) state_q <= S_ID;
        S_ID: begin
          if (is_j || is_jal) begin
            state_q    <= S_IF;
            retire_cnt <= retire_cnt + CNT_W'(1);
          end else if (legal) begin
            state_q <= S_EX;
          end else begin
            state_q <= S_IF;
          end
        end
        S_EX: begin
          if (is_br) begin
            state_q    <= S_IF;
            retire_cnt <= retire_cnt + CNT_W'(1);
          end else if (is_lw || is_sw) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_rdy) begin
            if (is_sw) begin
              state_q    <= S_IF;
              retire_cnt <= retire_cnt + CNT_W'(1);
            end else begin
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          state_q    <= S_IF;
          retire_cnt <= retire_cnt + CNT_W'(1);
        end
        default: state_q <= S_IF;
      endcase
    end
  end

  assign state = state_q;

  // Control outputs are decoded from state; reset gates them all low immediately.
  always_comb begin
    pc_we = 1'b0; ir_we = 1'b0; iord = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    reg_we = 1'b0; regdst = 1'b0; m2reg = 1'b0; jal = 1'b0; sext = 1'b0;
    alusrca = 2'd0; alusrcb = 2'd0; aluc = ALU_ADD; pcsrc = 2'd0; illegal = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IF: begin
          mem_re  = 1'b1;
          alusrcb = 2'd1;
          if (mem_rdy) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        S_ID: begin
          alusrcb = 2'd3;
          sext    = 1'b1;
          if (is_j || is_jal) begin
            pc_we = 1'b1;
            pcsrc = 2'd2;
          end
          if (is_jal) begin
            reg_we = 1'b1;
            jal    = 1'b1;
          end
          illegal = !legal;
        end
        S_EX: begin
          if (is_r) begin
            alusrca = is_shift ? 2'd2 : 2'd1;
            aluc    = r_aluc;
          end else if (is_ialu) begin
            alusrca = 2'd1;
            alusrcb = 2'd2;
            aluc    = i_aluc;
            sext    = (op == OP_ADDI);
          end else if (is_lw || is_sw) begin
            alusrca = 2'd1;
            alusrcb = 2'd2;
            sext    = 1'b1;
          end else if (is_br) begin
            alusrca = 2'd1;
            aluc    = ALU_SUB;
            pcsrc   = 2'd1;
            pc_we   = (op == OP_BEQ) ? z : !z;
          end
        end
        S_MEM: begin
          iord   = 1'b1;
          mem_re = is_lw;
          mem_we = is_sw;
        end
        S_WB: begin
          reg_we = 1'b1;
          m2reg  = is_lw;
          regdst = is_r;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes per-cycle expectations, a monitor compares them.
// Define MC_CTRL_HAMMING_EN for both bench and RTL to exercise the ham instruction.
module tb_mc_control;

  localparam int CNT_W = 4;

  logic clock = 1'b0, reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic z = 1'b0, mem_rdy = 1'b1;
  logic pc_we, ir_we, iord, mem_re, mem_we, reg_we, regdst, m2reg, jal, sext, illegal;
  logic [1:0] alusrca, alusrcb, pcsrc;
  logic [3:0] aluc;
  logic [2:0] state;
  logic [CNT_W-1:0] retire_cnt;

  mc_control #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we),
    .reg_we(reg_we), .regdst(regdst), .m2reg(m2reg), .jal(jal), .sext(sext),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsrc(pcsrc),
    .illegal(illegal), .state(state), .retire_cnt(retire_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic pc_we, ir_we, iord, mem_re, mem_we, reg_we, regdst, m2reg, jal, sext;
    logic [1:0] alusrca, alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsrc;
    logic illegal;
    logic [2:0] state;
    logic [CNT_W-1:0] retire_cnt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  e;
    obs_t  m;
  } item_t;

  item_t      sb[$];
  obs_t       e, m, act;
  logic [CNT_W-1:0] cnt = '0;
  int         tests = 0, fails = 0;

  assign act = '{pc_we, ir_we, iord, mem_re, mem_we, reg_we, regdst, m2reg, jal, sext,
                 alusrca, alusrcb, aluc, pcsrc, illegal, state, retire_cnt};

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      tests++;
      if (((act ^ it.e) & it.m) != '0) begin
        fails++;
        $display("FAIL %s: got %h expected %h (care %h)", it.name, act, it.e, it.m);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
    $fatal(1, "timeout");
  end

  // Enables, illegal, state and counter are always checked; callers add mux fields of interest.
  task automatic base(input logic [2:0] st);
    e = '0;
    e.state = st;
    e.retire_cnt = cnt;
    m = '0;
    m.pc_we = 1'b1; m.ir_we = 1'b1; m.mem_re = 1'b1; m.mem_we = 1'b1; m.reg_we = 1'b1;
    m.illegal = 1'b1; m.state = '1; m.retire_cnt = '1;
  endtask

  task automatic push_step(input string name);
    item_t it;
    it.name = name; it.e = e; it.m = m;
    sb.push_back(it);
    @(posedge clock); #1;
  endtask

  task automatic t_if(input string name, input logic rdy);
    mem_rdy = rdy;
    base(3'd0);
    e.mem_re = 1'b1; e.alusrcb = 2'd1;
    m.iord = 1'b1; m.alusrca = '1; m.alusrcb = '1; m.aluc = '1;
    if (rdy) begin
      e.ir_we = 1'b1; e.pc_we = 1'b1; m.pcsrc = '1;
    end
    push_step(name);
  endtask

  task automatic t_id(input string name);
    mem_rdy = 1'b1;
    base(3'd1);
    e.alusrcb = 2'd3; e.sext = 1'b1;
    m.alusrca = '1; m.alusrcb = '1; m.aluc = '1; m.sext = 1'b1;
    push_step(name);
  endtask

  task automatic t_ex(input string name, input logic [1:0] a, input logic [1:0] b,
                      input logic [3:0] c, input logic s);
    base(3'd2);
    e.alusrca = a; e.alusrcb = b; e.aluc = c; e.sext = s;
    m.alusrca = '1; m.alusrcb = '1; m.aluc = '1; m.sext = 1'b1;
    push_step(name);
  endtask

  task automatic t_wb(input string name, input logic rd, input logic m2);
    base(3'd4);
    e.reg_we = 1'b1; e.regdst = rd; e.m2reg = m2;
    m.regdst = 1'b1; m.m2reg = 1'b1; m.jal = 1'b1;
    push_step(name);
    cnt++;
  endtask

  task automatic t_branch(input string name, input logic [5:0] o, input logic zv,
                          input logic exp_we);
    op = o; func = 6'h00;
    t_if({name, "_if"}, 1'b1);
    t_id({name, "_id"});
    z = zv;
    base(3'd2);
    e.alusrca = 2'd1; e.alusrcb = 2'd0; e.aluc = 4'b0100; e.pc_we = exp_we; e.pcsrc = 2'd1;
    m.alusrca = '1; m.alusrcb = '1; m.aluc = '1; m.pcsrc = '1;
    push_step({name, "_ex"});
    z = 1'b0;
    cnt++;
  endtask

  task automatic t_jump(input string name, input logic link);
    op = link ? 6'b000011 : 6'b000010;
    t_if({name, "_if"}, 1'b1);
    base(3'd1);
    e.pc_we = 1'b1; e.pcsrc = 2'd2; e.reg_we = link; e.jal = link;
    m.pcsrc = '1; m.jal = 1'b1;
    push_step({name, "_id"});
    cnt++;
  endtask

  initial begin
    @(posedge clock); #1;
    // Reset held with mem_rdy high: IF would otherwise request and write.
    base(3'd0); m = '1;
    push_step("reset_outputs");
    reset = 1'b0;

    op = 6'b000000; func = 6'b100000;
    t_if("add_if", 1'b1); t_id("add_id");
    t_ex("add_ex", 2'd1, 2'd0, 4'b0000, 1'b0);
    t_wb("add_wb", 1'b1, 1'b0);

    func = 6'b000000;
    t_if("sll_if", 1'b1); t_id("sll_id");
    t_ex("sll_ex", 2'd2, 2'd0, 4'b0011, 1'b0);
    t_wb("sll_wb", 1'b1, 1'b0);

    func = 6'b000011;
    t_if("sra_if", 1'b1); t_id("sra_id");
    t_ex("sra_ex", 2'd2, 2'd0, 4'b1111, 1'b0);
    t_wb("sra_wb", 1'b1, 1'b0);

    op = 6'b001000; func = 6'h15;
    t_if("addi_if", 1'b1); t_id("addi_id");
    t_ex("addi_ex", 2'd1, 2'd2, 4'b0000, 1'b1);
    t_wb("addi_wb", 1'b0, 1'b0);

    op = 6'b001101;
    t_if("ori_if", 1'b1); t_id("ori_id");
    t_ex("ori_ex", 2'd1, 2'd2, 4'b0101, 1'b0);
    t_wb("ori_wb", 1'b0, 1'b0);

    op = 6'b001111;
    t_if("lui_if", 1'b1); t_id("lui_id");
    t_ex("lui_ex", 2'd1, 2'd2, 4'b0110, 1'b0);
    t_wb("lui_wb", 1'b0, 1'b0);

    // lw with an IF stall and a three-cycle MEM stall
    op = 6'b100011;
    t_if("if_stall0", 1'b0); t_if("if_stall1", 1'b0);
    t_if("lw_if", 1'b1); t_id("lw_id");
    base(3'd2); e.aluc = 4'b0000; e.sext = 1'b1; m.aluc = '1; m.sext = 1'b1;
    push_step("lw_ex");
    for (int i = 0; i < 4; i++) begin
      mem_rdy = (i == 3);
      base(3'd3); e.iord = 1'b1; e.mem_re = 1'b1; m.iord = 1'b1;
      push_step($sformatf("lw_mem%0d", i));
    end
    t_wb("lw_wb", 1'b0, 1'b1);

    op = 6'b101011;
    t_if("sw_if", 1'b1); t_id("sw_id");
    base(3'd2); e.aluc = 4'b0000; e.sext = 1'b1; m.aluc = '1; m.sext = 1'b1;
    push_step("sw_ex");
    for (int i = 0; i < 2; i++) begin
      mem_rdy = (i == 1);
      base(3'd3); e.iord = 1'b1; e.mem_we = 1'b1; m.iord = 1'b1;
      push_step($sformatf("sw_mem%0d", i));
    end
    cnt++;

    t_branch("beq_z1", 6'b000100, 1'b1, 1'b1);
    t_branch("beq_z0", 6'b000100, 1'b0, 1'b0);
    t_branch("bne_z1", 6'b000101, 1'b1, 1'b0);
    t_branch("bne_z0", 6'b000101, 1'b0, 1'b1);

    t_jump("j", 1'b0);
    t_jump("jal", 1'b1);

    op = 6'b111111;
    t_if("bad_op_if", 1'b1);
    base(3'd1); e.illegal = 1'b1;
    push_step("bad_op_id");

    op = 6'b000000; func = 6'b111000;
    t_if("ham_if", 1'b1);
`ifdef MC_CTRL_HAMMING_EN
    t_id("ham_id");
    t_ex("ham_ex", 2'd1, 2'd0, 4'b1011, 1'b0);
    t_wb("ham_wb", 1'b1, 1'b0);
`else
    base(3'd1); e.illegal = 1'b1;
    push_step("ham_illegal_id");
`endif

    // Enough jumps to carry the 4-bit counter through 15 -> 0.
    for (int i = 0; i < 16; i++) t_jump($sformatf("wrap%0d", i), 1'b0);

    // Reset while sw is stalled in MEM with mem_we asserted.
    op = 6'b101011;
    t_if("rsw_if", 1'b1); t_id("rsw_id");
    base(3'd2); m.state = '1;
    push_step("rsw_ex");
    mem_rdy = 1'b0;
    base(3'd3); e.iord = 1'b1; e.mem_we = 1'b1; m.iord = 1'b1;
    push_step("rsw_mem");
    reset = 1'b1;
    cnt = '0;
    base(3'd0); m = '1;
    push_step("rsw_reset");
    reset = 1'b0;
    t_if("post_reset_if", 1'b1);
    t_id("post_reset_id");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
